// File: rtl/kmap_mux_sweep_pkg.sv
// rtl/kmap_mux_sweep_pkg.sv - shared types, golden table and popcount for the K-map mux sweep checker
package kmap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] KMAP_GOLDEN = 16'h850E;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/kmap_mux_sweep_if.sv
// rtl/kmap_mux_sweep_if.sv - control, generator and result signals of the K-map mux sweep checker
interface kmap_mux_sweep_if;

  logic        start;
  logic        c_out;
  logic        d_out;
  logic [3:0]  mux_in;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic        pass;
  logic [4:0]  mismatch_cnt;

  modport master (
    input  start,
    input  mux_in,
    output c_out,
    output d_out,
    output busy,
    output done,
    output truth_table,
    output pass,
    output mismatch_cnt
  );

  modport slave (
    output start,
    output mux_in,
    input  c_out,
    input  d_out,
    input  busy,
    input  done,
    input  truth_table,
    input  pass,
    input  mismatch_cnt
  );

endinterface

// File: rtl/kmap_mux_sweep.sv
// rtl/kmap_mux_sweep.sv - sweeps cd over the mux-input generator and checks the captured truth table
module kmap_mux_sweep
  import kmap_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = KMAP_GOLDEN
) (
  input  logic           clk,
  input  logic           reset,
  kmap_mux_sweep_if.master sw
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_DRIVE  = DRIVE;
  localparam logic [1:0] S_SAMPLE = SAMPLE;
  localparam logic [1:0] S_DONE   = DONE;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  cd;
  logic [3:0]  wait_cnt;
  logic        c_q;
  logic        d_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] table_q;
  logic        pass_q;
  logic [4:0]  mis_q;
  logic [15:0] table_next;

  // Bit k of mux_in is f at ab = k for the cd currently driven.
  always_comb begin
    table_next = table_q;
    for (int k = 0; k < 4; k++) begin
      table_next[{2'(k), cd}] = sw.mux_in[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cd       <= 2'd0;
      wait_cnt <= 4'd0;
      c_q      <= 1'b0;
      d_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= 16'd0;
      pass_q   <= 1'b0;
      mis_q    <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sw.start) begin
            state    <= S_DRIVE;
            cd       <= 2'd0;
            wait_cnt <= 4'd0;
            c_q      <= 1'b0;
            d_q      <= 1'b0;
            busy_q   <= 1'b1;
            table_q  <= 16'd0;
            pass_q   <= 1'b0;
            mis_q    <= 5'd0;
          end
        end
        S_DRIVE: begin
          if (wait_cnt == SETTLE_LAST) begin
            state    <= S_SAMPLE;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          table_q <= table_next;
          if (cd == 2'd3) begin
            // Results are taken from the completed table so they are valid alongside done.
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (table_next == EXPECTED);
            mis_q  <= popcount16(table_next ^ EXPECTED);
          end else begin
            state        <= S_DRIVE;
            cd           <= cd + 2'd1;
            {c_q, d_q}   <= cd + 2'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          c_q   <= 1'b0;
          d_q   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sw.c_out        = c_q;
  assign sw.d_out        = d_q;
  assign sw.busy         = busy_q;
  assign sw.done         = done_q;
  assign sw.truth_table  = table_q;
  assign sw.pass         = pass_q;
  assign sw.mismatch_cnt = mis_q;

endmodule

// File: tb/tb_kmap_mux_sweep.sv
// tb/tb_kmap_mux_sweep.sv - self-checking bench for kmap_mux_sweep with SETTLE_CYCLES 1 and 3
module tb_kmap_mux_sweep;

  localparam logic [15:0] GOLD = 16'h850E;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic       chk_en = 1'b0;
  int         mode [2];
  int         t [2];
  logic [15:0] m_tt [2];
  logic        m_pass [2];
  logic [4:0]  m_mis [2];

  kmap_mux_sweep_if ifa ();
  kmap_mux_sweep_if ifb ();

  kmap_mux_sweep #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .reset(rst[0]), .sw(ifa));
  kmap_mux_sweep #(.SETTLE_CYCLES(3)) dut_b (.clk(clk), .reset(rst[1]), .sw(ifb));

  always @(posedge clk) cyc <= cyc + 1;

  // Generator: 0 golden, 1 stuck at zero, 2 golden with mux_in[2] forced low at cd=10.
  function automatic logic gen_bit(input int md, input int k, input int cdv);
    logic [15:0] g;
    int          idx;
    g   = GOLD;
    idx = k * 4 + cdv;
    if (md == 1) return 1'b0;
    if (md == 2 && k == 2 && cdv == 2) return 1'b0;
    return g[idx];
  endfunction

  function automatic logic [3:0] gen_vec(input int md, input logic c, input logic d);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = gen_bit(md, k, {30'd0, c, d});
    return v;
  endfunction

  function automatic logic [15:0] table_of(input int md);
    logic [15:0] tt;
    for (int idx = 0; idx < 16; idx++) tt[idx] = gen_bit(md, idx / 4, idx % 4);
    return tt;
  endfunction

  function automatic int settle_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int dlen(input int i);
    return 4 * (settle_of(i) + 1) + 1;
  endfunction

  always_comb ifa.mux_in = gen_vec(mode[0], ifa.c_out, ifa.d_out);
  always_comb ifb.mux_in = gen_vec(mode[1], ifb.c_out, ifb.d_out);

  function automatic logic start_of(input int i);
    return (i == 1) ? ifb.start : ifa.start;
  endfunction
  function automatic logic done_of(input int i);
    return (i == 1) ? ifb.done : ifa.done;
  endfunction
  function automatic logic [1:0] cd_of(input int i);
    return (i == 1) ? {ifb.c_out, ifb.d_out} : {ifa.c_out, ifa.d_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: t counts cycles since the accepting edge; 0 means idle, dlen means the done cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        t[i] = 0; m_tt[i] = 16'd0; m_pass[i] = 1'b0; m_mis[i] = 5'd0;
      end else if (t[i] == 0) begin
        if (start_of(i)) begin
          t[i] = 1; m_tt[i] = 16'd0; m_pass[i] = 1'b0; m_mis[i] = 5'd0;
        end
      end else if (t[i] == dlen(i)) begin
        t[i] = 0;
      end else begin
        t[i] = t[i] + 1;
        if (t[i] == dlen(i)) begin
          m_tt[i]   = table_of(mode[i]);
          m_pass[i] = (m_tt[i] == GOLD);
          m_mis[i]  = 5'($countones(m_tt[i] ^ GOLD));
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic busy, input logic done, input logic [1:0] cdv,
                          input logic [15:0] tt, input logic p, input logic [4:0] mc);
    int n;
    n = dlen(i);
    chk($sformatf("busy[%0d]", i), 32'(busy), 32'(t[i] >= 1 && t[i] < n));
    chk($sformatf("done[%0d]", i), 32'(done), 32'(t[i] == n));
    if (t[i] >= 1 && t[i] < n) chk($sformatf("cd[%0d]", i), 32'(cdv), 32'((t[i] - 1) / (settle_of(i) + 1)));
    if (t[i] == 0) chk($sformatf("cd_idle[%0d]", i), 32'(cdv), 32'd0);
    if (t[i] == 0 || t[i] == n) begin
      chk($sformatf("table[%0d]", i), 32'(tt), 32'(m_tt[i]));
      chk($sformatf("pass[%0d]", i), 32'(p), 32'(m_pass[i]));
      chk($sformatf("mis[%0d]", i), 32'(mc), 32'(m_mis[i]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, ifa.busy, ifa.done, {ifa.c_out, ifa.d_out}, ifa.truth_table, ifa.pass, ifa.mismatch_cnt);
      cmp_inst(1, ifb.busy, ifb.done, {ifb.c_out, ifb.d_out}, ifb.truth_table, ifb.pass, ifb.mismatch_cnt);
    end
  end

  task automatic set_start(input int i, input logic v);
    if (i == 1) ifb.start = v; else ifa.start = v;
  endtask

  task automatic run_sweep(input int i, input int md, output int lat, output logic [31:0] seq);
    int n;
    mode[i] = md;
    @(negedge clk);
    set_start(i, 1'b1);
    n = cyc;
    @(negedge clk);
    set_start(i, 1'b0);
    seq = 32'd0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done_of(i)) begin
        lat = cyc - n;
        break;
      end
      seq = {seq[29:0], cd_of(i)};
      @(negedge clk);
    end
  endtask

  initial begin
    int          lat;
    int          n;
    int          cnt;
    int          offs [3];
    logic [31:0] seq;

    mode[0] = 0; mode[1] = 0;
    rst = 2'b11;
    ifa.start = 1'b0; ifb.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_cd", 32'({ifa.c_out, ifa.d_out}), 32'd0);
    chk("rst_table", 32'(ifa.truth_table), 32'd0);
    chk("rst_pass_mis", 32'({ifb.pass, ifb.mismatch_cnt}), 32'd0);
    rst = 2'b00;
    chk_en = 1'b1;

    run_sweep(0, 0, lat, seq);
    chk("golden_lat", 32'(lat), 32'd9);
    chk("golden_seq", seq, 32'h0000_05AF);
    chk("golden_table", 32'(ifa.truth_table), 32'h850E);
    chk("golden_pass", 32'(ifa.pass), 32'd1);
    chk("golden_mis", 32'(ifa.mismatch_cnt), 32'd0);

    run_sweep(0, 1, lat, seq);
    chk("stuck_table", 32'(ifa.truth_table), 32'h0000);
    chk("stuck_pass", 32'(ifa.pass), 32'd0);
    chk("stuck_mis", 32'(ifa.mismatch_cnt), 32'd6);

    run_sweep(0, 2, lat, seq);
    chk("fault_table", 32'(ifa.truth_table), 32'h810E);
    chk("fault_pass", 32'(ifa.pass), 32'd0);
    chk("fault_mis", 32'(ifa.mismatch_cnt), 32'd1);
    @(negedge clk);
    chk("fault_table_held", 32'(ifa.truth_table), 32'h810E);

    run_sweep(1, 0, lat, seq);
    chk("s3_lat", 32'(lat), 32'd17);
    chk("s3_seq", seq, 32'h0055_AAFF);
    chk("s3_pass", 32'(ifb.pass), 32'd1);

    mode[0] = 0;
    @(negedge clk);
    ifa.start = 1'b1;
    n = cyc;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ifa.done) begin
        if (cnt < 3) offs[cnt] = cyc - n;
        cnt++;
      end
    end
    ifa.start = 1'b0;
    chk("held_count", 32'(cnt), 32'd3);
    if (cnt == 3) begin
      chk("held_done0", 32'(offs[0]), 32'd9);
      chk("held_done1", 32'(offs[1]), 32'd19);
      chk("held_done2", 32'(offs[2]), 32'd29);
    end
    repeat (3) @(negedge clk);

    @(negedge clk);
    ifa.start = 1'b1;
    n = cyc;
    @(negedge clk);
    ifa.start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 2 || k == 5) ifa.start = 1'b1;
      else ifa.start = 1'b0;
      if (ifa.done) begin
        cnt++;
        chk("pulse_lat", 32'(cyc - n), 32'd9);
      end
      @(negedge clk);
    end
    ifa.start = 1'b0;
    chk("pulse_count", 32'(cnt), 32'd1);

    @(negedge clk);
    ifb.start = 1'b1;
    n = cyc;
    @(negedge clk);
    ifb.start = 1'b0;
    for (int k = 0; k < 40 && cyc < n + 10; k++) @(negedge clk);
    chk("rst_mid_cd", 32'({ifb.c_out, ifb.d_out}), 32'd2);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rst_mid_busy", 32'(ifb.busy), 32'd0);
    chk("rst_mid_cdout", 32'({ifb.c_out, ifb.d_out}), 32'd0);
    chk("rst_mid_table", 32'(ifb.truth_table), 32'd0);
    chk("rst_mid_pass", 32'(ifb.pass), 32'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (ifb.done) cnt++;
      @(negedge clk);
    end
    chk("rst_mid_nodone", 32'(cnt), 32'd0);

    run_sweep(1, 0, lat, seq);
    chk("after_rst_lat", 32'(lat), 32'd17);
    chk("after_rst_table", 32'(ifb.truth_table), 32'h850E);
    chk("after_rst_pass", 32'(ifb.pass), 32'd1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
